// File: rtl/input_process_uart_gen2.sv
//==============================================================================
//  Module   : input_process_uart_gen2
//  Purpose  : UART-side input packer. Packs received bytes MSB-first into
//             BYTES_PER_WORD-byte words in an internal word FIFO. Reports the
//             message length and the pad count on MSG_START. Raises
//             GOT_FULL_MESSAGE on a word threshold or on an idle gap.
//  Ports    : CLK, RST (sync, active-high)
//             rx_data/rx_valid/rx_ready : byte input with backpressure
//             RD_REQ / FIFO_Q           : word pop and registered read data
//             MSG_START                 : snapshot length/pad, stuff partial word
//             MSG_LEN, MSG_PAD          : message info
//             GOT_FULL_MESSAGE          : message ready for readout
//             MSG_CSUM                  : XOR checksum (INPUT_PROC_UART_CSUM_EN only)
//  Options  : `define INPUT_PROC_UART_CSUM_EN adds the MSG_CSUM port and logic
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module input_process_uart_gen2 #(
    parameter int BYTES_PER_WORD = 2,
    parameter int DEPTH_WORDS    = 128,
    parameter int FULL_WORDS     = 128,
    parameter int GFM_LIMIT      = 1000,
    parameter int MAX_LEN        = 254,
    parameter int LEN_W          = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic                              rx_ready,
    input  logic                              RD_REQ,
    input  logic                              MSG_START,
    output logic [8*BYTES_PER_WORD-1:0]       FIFO_Q,
    output logic [LEN_W-1:0]                  MSG_LEN,
    output logic [$clog2(BYTES_PER_WORD)-1:0] MSG_PAD,
    output logic                              GOT_FULL_MESSAGE
`ifdef INPUT_PROC_UART_CSUM_EN
    ,
    output logic [7:0]                        MSG_CSUM
`endif
);

    localparam int c_WORD_W = 8 * BYTES_PER_WORD;
    localparam int c_IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int c_AW     = $clog2(DEPTH_WORDS);
    localparam int c_TMR_W  = $clog2(GFM_LIMIT + 1);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [c_AW:0]      c_DEPTH    = (c_AW+1)'(DEPTH_WORDS);
    localparam logic [c_AW:0]      c_FULLW    = (c_AW+1)'(FULL_WORDS);
    localparam logic [c_TMR_W-1:0] c_LIMIT    = c_TMR_W'(GFM_LIMIT);

    logic [c_WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [c_AW-1:0]     r_wptr;
    logic [c_AW-1:0]     r_rptr;
    logic [c_AW:0]       r_count;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_WORD_W-1:0] r_word;
    logic [c_TMR_W-1:0]  r_timer;

    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_stuff;
    logic                w_push;
    logic                w_pop;
    logic                w_partial;
    logic [c_IDX_W-1:0]  w_pad_bytes;
    logic [c_WORD_W-1:0] w_shift_word;
    logic [c_WORD_W-1:0] w_stuff_word;
    logic [c_WORD_W-1:0] w_push_word;
    logic [31:0]         w_len_sum;
    logic [LEN_W-1:0]    w_len;
    logic                w_gfm_set;

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_partial = (r_idx != '0);
    assign rx_ready  = ~w_full;
    assign w_accept  = rx_valid & ~w_full;

    // A byte arriving in the MSG_START cycle wins: the partial word then
    // carries over into the next message instead of being padded out.
    assign w_stuff   = MSG_START & w_partial & ~rx_valid & ~w_full;
    assign w_push    = (w_accept & (r_idx == c_IDX_LAST)) | w_stuff;
    assign w_pop     = RD_REQ & ~w_empty;

    // Modular subtraction is exact here because idx >= 1 whenever it is used.
    assign w_pad_bytes  = c_IDX_W'(BYTES_PER_WORD) - r_idx;
    assign w_shift_word = {r_word[c_WORD_W-9:0], rx_data};
    // The low idx bytes of the shift register hold the partial word; shifting
    // left drops stale upper bytes and fills the pad bytes with zeros.
    assign w_stuff_word = r_word << {w_pad_bytes, 3'b000};
    assign w_push_word  = w_stuff ? w_stuff_word : w_shift_word;

    // 32-bit sum is wide enough that min() cannot be fooled by wrap-around.
    assign w_len_sum = 32'(r_count) + 32'(w_partial);
    assign w_len     = (w_full || (w_len_sum > 32'(MAX_LEN))) ? LEN_W'(MAX_LEN)
                                                              : w_len_sum[LEN_W-1:0];

    assign w_gfm_set = ((r_timer == c_LIMIT) && (!w_empty || w_partial)) ||
                       (r_count >= c_FULLW);

    // Word storage has no reset; the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            FIFO_Q  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                FIFO_Q <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte assembler and message snapshot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx   <= '0;
            r_word  <= '0;
            MSG_LEN <= '0;
            MSG_PAD <= '0;
        end else begin
            if (w_accept) begin
                r_word <= w_shift_word;
                r_idx  <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else if (w_stuff) begin
                r_idx  <= '0;
            end
            if (MSG_START) begin
                MSG_LEN <= w_len;
                MSG_PAD <= w_stuff ? w_pad_bytes : '0;
            end
        end
    end

    // Idle timer and sticky ready flag; a read both restarts the gap and
    // acknowledges the flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer          <= '0;
            GOT_FULL_MESSAGE <= 1'b0;
        end else begin
            if (w_accept || RD_REQ) begin
                r_timer <= '0;
            end else if (r_timer != c_LIMIT) begin
                r_timer <= r_timer + 1'b1;
            end
            if (RD_REQ) begin
                GOT_FULL_MESSAGE <= 1'b0;
            end else if (w_gfm_set) begin
                GOT_FULL_MESSAGE <= 1'b1;
            end
        end
    end

`ifdef INPUT_PROC_UART_CSUM_EN
    logic [7:0] r_csum_run;

    // Pad bytes never enter the XOR; a byte accepted with MSG_START seeds
    // the next message's checksum.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_csum_run <= 8'h00;
            MSG_CSUM   <= 8'h00;
        end else if (MSG_START) begin
            MSG_CSUM   <= r_csum_run;
            r_csum_run <= w_accept ? rx_data : 8'h00;
        end else if (w_accept) begin
            r_csum_run <= r_csum_run ^ rx_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_process_uart_gen2.sv
//==============================================================================
//  Module   : tb_input_process_uart_gen2
//  Purpose  : Self-checking bench for input_process_uart_gen2. Main instance
//             uses BPW=2, 8-word FIFO, threshold 8, idle gap 20, MAX_LEN=8 (so
//             a full FIFO reports 8 words). A second instance uses BPW=4 and
//             MAX_LEN=3 for the saturation/padding case.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_input_process_uart_gen2;

    localparam int BPW   = 2;
    localparam int DEPTH = 8;
    localparam int FULLW = 8;
    localparam int LIM   = 20;
    localparam int MAXL  = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready, RD_REQ, MSG_START, GOT;
    logic [15:0] FIFO_Q;
    logic [7:0]  MSG_LEN;
    logic [0:0]  MSG_PAD;

    logic [7:0]  d4;
    logic        v4, rdy4, rd4, ms4, gfm4;
    logic [31:0] q4;
    logic [7:0]  len4;
    logic [1:0]  pad4;
`ifdef INPUT_PROC_UART_CSUM_EN
    logic [7:0]  MSG_CSUM, csum4;
`endif

    always #5 CLK = ~CLK;

    input_process_uart_gen2 #(
        .BYTES_PER_WORD(BPW), .DEPTH_WORDS(DEPTH), .FULL_WORDS(FULLW),
        .GFM_LIMIT(LIM), .MAX_LEN(MAXL), .LEN_W(8)
    ) u_dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .RD_REQ(RD_REQ), .MSG_START(MSG_START),
        .FIFO_Q(FIFO_Q), .MSG_LEN(MSG_LEN), .MSG_PAD(MSG_PAD),
        .GOT_FULL_MESSAGE(GOT)
`ifdef INPUT_PROC_UART_CSUM_EN
        , .MSG_CSUM(MSG_CSUM)
`endif
    );

    input_process_uart_gen2 #(
        .BYTES_PER_WORD(4), .DEPTH_WORDS(8), .FULL_WORDS(8),
        .GFM_LIMIT(20), .MAX_LEN(3), .LEN_W(8)
    ) u_dut4 (
        .CLK(CLK), .RST(RST), .rx_data(d4), .rx_valid(v4),
        .rx_ready(rdy4), .RD_REQ(rd4), .MSG_START(ms4),
        .FIFO_Q(q4), .MSG_LEN(len4), .MSG_PAD(pad4),
        .GOT_FULL_MESSAGE(gfm4)
`ifdef INPUT_PROC_UART_CSUM_EN
        , .MSG_CSUM(csum4)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model (main instance) ----------
    logic [15:0] m_words[$];
    logic [7:0]  m_part[$];
    int          m_timer;
    bit          m_gfm;
    logic [15:0] m_q;
    logic [7:0]  m_len;
    int          m_pad;
    logic [7:0]  m_run, m_csum;

    function automatic void m_reset();
        m_words.delete(); m_part.delete();
        m_timer = 0; m_gfm = 0; m_q = 0; m_len = 0; m_pad = 0;
        m_run = 0; m_csum = 0;
    endfunction

    function automatic logic [15:0] pack_part();
        logic [15:0] w;
        w = 0;
        foreach (m_part[i]) w = (w << 8) | 16'(m_part[i]);
        return w << (8 * (BPW - m_part.size()));
    endfunction

    function automatic void m_step(bit v, logic [7:0] d, bit rd, bit ms);
        bit full, empty, acc, gfm_n;
        int n;
        full  = (m_words.size() == DEPTH);
        empty = (m_words.size() == 0);
        acc   = v && !full;
        if (rd) gfm_n = 0;
        else if ((m_timer == LIM && (!empty || m_part.size() > 0)) || m_words.size() >= FULLW) gfm_n = 1;
        else gfm_n = m_gfm;
        if (rd && !empty) m_q = m_words.pop_front();
        if (ms) begin
            n      = m_words.size() + ((rd && !empty) ? 1 : 0) + (m_part.size() > 0 ? 1 : 0);
            m_len  = full ? 8'(MAXL) : 8'((n > MAXL) ? MAXL : n);
            m_csum = m_run;
            m_run  = 0;
            if (m_part.size() > 0 && !v && !full) begin
                m_pad = BPW - m_part.size();
                m_words.push_back(pack_part());
                m_part.delete();
            end else begin
                m_pad = 0;
            end
        end
        if (acc) begin
            m_run ^= d;
            m_part.push_back(d);
            if (m_part.size() == BPW) begin
                m_words.push_back(pack_part());
                m_part.delete();
            end
        end
        m_timer = (acc || rd) ? 0 : ((m_timer < LIM) ? m_timer + 1 : LIM);
        m_gfm   = gfm_n;
    endfunction

    // ---------------- drivers ----------------------------------------------
    task automatic drive(input bit v, input logic [7:0] d, input bit rd, input bit ms);
        rx_valid = v; rx_data = d; RD_REQ = rd; MSG_START = ms;
        @(posedge CLK); #1;
    endtask

    task automatic mstep(input bit v, input logic [7:0] d, input bit rd, input bit ms, input int c);
        chk($sformatf("m%0d_rx_ready", c), rx_ready, m_words.size() != DEPTH);
        m_step(v, d, rd, ms);
        drive(v, d, rd, ms);
        chk($sformatf("m%0d_fifo_q", c), FIFO_Q, m_q);
        chk($sformatf("m%0d_msg_len", c), MSG_LEN, m_len);
        chk($sformatf("m%0d_msg_pad", c), MSG_PAD, m_pad);
        chk($sformatf("m%0d_gfm", c), GOT, m_gfm);
`ifdef INPUT_PROC_UART_CSUM_EN
        chk($sformatf("m%0d_csum", c), MSG_CSUM, m_csum);
`endif
    endtask

    task automatic drive4(input bit v, input logic [7:0] d, input bit rd, input bit ms);
        v4 = v; d4 = d; rd4 = rd; ms4 = ms;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        RST = 1'b0;
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        string       name;
        bit          v;
        logic [7:0]  d;
        bit          rd;
        bit          ms;
        int          rep;
        bit          e_rdy;
        logic [15:0] e_q;
        logic [7:0]  e_len;
        logic [0:0]  e_pad;
        bit          e_gfm;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int c;
        vecs = '{
            '{"t1_b0",      1, 8'h11, 0, 0,  1, 1, 16'h0000, 8'd0, 1'b0, 0},
            '{"t1_b1",      1, 8'h22, 0, 0,  1, 1, 16'h0000, 8'd0, 1'b0, 0},
            '{"t1_b2",      1, 8'h33, 0, 0,  1, 1, 16'h0000, 8'd0, 1'b0, 0},
            '{"t1_idle20",  0, 8'h00, 0, 0, 20, 1, 16'h0000, 8'd0, 1'b0, 0},
            '{"t1_idle21",  0, 8'h00, 0, 0,  1, 1, 16'h0000, 8'd0, 1'b0, 1},
            '{"t1_start",   0, 8'h00, 0, 1,  1, 1, 16'h0000, 8'd2, 1'b1, 1},
            '{"t1_rd0",     0, 8'h00, 1, 0,  1, 1, 16'h1122, 8'd2, 1'b1, 0},
            '{"t1_rd1",     0, 8'h00, 1, 0,  1, 1, 16'h3300, 8'd2, 1'b1, 0},
            '{"t1_rd_empty",0, 8'h00, 1, 0,  1, 1, 16'h3300, 8'd2, 1'b1, 0},
            '{"t2_b0",      1, 8'hAA, 0, 0,  1, 1, 16'h3300, 8'd2, 1'b1, 0},
            '{"t2_b1",      1, 8'hBB, 0, 0,  1, 1, 16'h3300, 8'd2, 1'b1, 0},
            '{"t2_start_b", 1, 8'h33, 0, 1,  1, 1, 16'h3300, 8'd1, 1'b0, 0},
            '{"t2_b3",      1, 8'h44, 0, 0,  1, 1, 16'h3300, 8'd1, 1'b0, 0},
            '{"t2_rd0",     0, 8'h00, 1, 0,  1, 1, 16'hAABB, 8'd1, 1'b0, 0},
            '{"t2_rd1",     0, 8'h00, 1, 0,  1, 1, 16'h3344, 8'd1, 1'b0, 0}
        };

        rx_valid = 0; rx_data = 0; RD_REQ = 0; MSG_START = 0;
        v4 = 0; d4 = 0; rd4 = 0; ms4 = 0;
        do_reset();

        chk("reset_fifo_q", FIFO_Q, 16'h0);
        chk("reset_msg_len", MSG_LEN, 8'h0);
        chk("reset_msg_pad", MSG_PAD, 1'b0);
        chk("reset_gfm", GOT, 1'b0);
        chk("reset_rx_ready", rx_ready, 1'b1);

        // Tests 1 and 2 from the table.
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++)
                drive(vecs[i].v, vecs[i].d, vecs[i].rd, vecs[i].ms);
            chk({vecs[i].name, "_rdy"}, rx_ready, vecs[i].e_rdy);
            chk({vecs[i].name, "_q"},   FIFO_Q,   vecs[i].e_q);
            chk({vecs[i].name, "_len"}, MSG_LEN,  vecs[i].e_len);
            chk({vecs[i].name, "_pad"}, MSG_PAD,  vecs[i].e_pad);
            chk({vecs[i].name, "_gfm"}, GOT,      vecs[i].e_gfm);
        end

        // Test 3: fill the FIFO; threshold flag without the idle timeout.
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(8'h80 + i), 0, 0);
            chk($sformatf("t3_rdy_after_%0d", i), rx_ready, (i < 15));
        end
        chk("t3_gfm_not_yet", GOT, 1'b0);
        drive(1, 8'h99, 0, 0);
        chk("t3_held_rdy", rx_ready, 1'b0);
        chk("t3_gfm_threshold", GOT, 1'b1);
        drive(1, 8'h99, 0, 1);
        chk("t3_len_full", MSG_LEN, 8'd8);
        chk("t3_pad_full", MSG_PAD, 1'b0);
        drive(1, 8'h99, 1, 0);
        chk("t3_rd_q", FIFO_Q, 16'h8081);
        chk("t3_rd_rdy", rx_ready, 1'b1);
        chk("t3_rd_gfm", GOT, 1'b0);
        drive(1, 8'h99, 0, 0);   // held byte finally accepted
        drive(0, 8'h00, 0, 0);

        // Test 5: reset mid-message discards everything, partial word included.
        RST = 1'b1;
        drive(0, 8'h00, 0, 0);
        RST = 1'b0;
        chk("t5_q", FIFO_Q, 16'h0);
        chk("t5_len", MSG_LEN, 8'h0);
        chk("t5_pad", MSG_PAD, 1'b0);
        chk("t5_gfm", GOT, 1'b0);
        chk("t5_rdy", rx_ready, 1'b1);
        drive(0, 8'h00, 1, 0);
        chk("t5_rd_empty_q", FIFO_Q, 16'h0);
        drive(1, 8'h12, 0, 0);
        drive(1, 8'h34, 0, 0);
        drive(0, 8'h00, 1, 0);
        chk("t5_fresh_word", FIFO_Q, 16'h1234);

        // Randomized phases against the reference model.
        do_reset();
        m_reset();
        c = 0;
        for (int ph = 0; ph < 24; ph++) begin
            int pv, prd, pms, n;
            pv  = (ph % 5 == 4) ? 3 : $urandom_range(10, 95);
            prd = (ph % 5 == 4) ? 0 : $urandom_range(0, 35);
            pms = $urandom_range(0, 12);
            n   = $urandom_range(60, 180);
            for (int k = 0; k < n; k++) begin
                mstep($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < prd,
                      $urandom_range(0, 99) < pms, c);
                c++;
            end
        end

`ifdef INPUT_PROC_UART_CSUM_EN
        // Test 6: checksum, pad bytes excluded.
        do_reset();
        m_reset();
        mstep(1, 8'h0F, 0, 0, c);
        mstep(1, 8'hF0, 0, 0, c);
        mstep(1, 8'h55, 0, 0, c);
        mstep(0, 8'h00, 0, 1, c);
        chk("t6_csum0", MSG_CSUM, 8'hAA);
        mstep(1, 8'h01, 0, 0, c);
        mstep(0, 8'h00, 0, 1, c);
        chk("t6_csum1", MSG_CSUM, 8'h01);
`endif

        // Test 4: BPW=4, MAX_LEN=3, 14 bytes -> saturated length, two pad bytes.
        do_reset();
        for (int i = 0; i < 14; i++) drive4(1, 8'(8'h10 + i), 0, 0);
        drive4(0, 8'h00, 0, 1);
        chk("t4_len_sat", len4, 8'd3);
        chk("t4_pad", pad4, 2'd2);
        drive4(0, 8'h00, 1, 0);
        chk("t4_word0", q4, 32'h10111213);
        drive4(0, 8'h00, 1, 0);
        drive4(0, 8'h00, 1, 0);
        drive4(0, 8'h00, 1, 0);
        chk("t4_last_word", q4, 32'h1C1D0000);
        for (int i = 0; i < 4; i++) drive4(1, 8'(8'hC0 + i), 0, 0);
        drive4(0, 8'h00, 1, 0);
        chk("t4_after_stuff", q4, 32'hC0C1C2C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
